// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: decode-side and pipeline-control signals of the stage-2
// controller in a 3-stage RV32I pipeline.
//   master : fetch/decode + execute side. It drives the instruction fields,
//            br_taken and md_done, and receives the stage-2 controls.
//   slave  : pipe_ctrl itself.
// Signals:
//   instr_valid, opcode, funct3, funct7 : fetched instruction to decode
//   br_taken                            : branch comparator result for stage 2
//   md_done                             : MUL/DIV unit result ready
//   alu_op, reg_write, read_en, write_en,
//   sel_A, sel_B, wb_sel, br_type       : registered stage-2 controls
//   ctrl_valid                          : stage 2 holds a real instruction
//   wb_en, PCen, flush, md_start, illegal : pipeline control strobes
interface pipe_ctrl_if;
  logic       instr_valid;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       br_taken;
  logic       md_done;

  logic [4:0] alu_op;
  logic       reg_write;
  logic       read_en;
  logic       write_en;
  logic       sel_A;
  logic       sel_B;
  logic [1:0] wb_sel;
  logic [1:0] br_type;
  logic       ctrl_valid;
  logic       wb_en;
  logic       PCen;
  logic       flush;
  logic       md_start;
  logic       illegal;

  modport master (
    output instr_valid, opcode, funct3, funct7, br_taken, md_done,
    input  alu_op, reg_write, read_en, write_en, sel_A, sel_B, wb_sel,
           br_type, ctrl_valid, wb_en, PCen, flush, md_start, illegal
  );

  modport slave (
    input  instr_valid, opcode, funct3, funct7, br_taken, md_done,
    output alu_op, reg_write, read_en, write_en, sel_A, sel_B, wb_sel,
           br_type, ctrl_valid, wb_en, PCen, flush, md_start, illegal
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: registered decode controller for a 3-stage RV32I pipeline.
// It decodes opcode/funct fields into a stage-2 control register. It also
// produces PC stall/enable, a flush for taken control flow, load wait states,
// the MUL/DIV start/done handshake and illegal-instruction pulses.
// Parameters:
//   LOAD_WAIT : extra stage-2 cycles per load (0..15, 0 = single-cycle load)
//   EN_MEXT   : 1 decodes the M extension, 0 treats it as illegal
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pipe_ctrl_if slave modport (decode inputs, stage-2 outputs)
module pipe_ctrl #(
  parameter int unsigned LOAD_WAIT = 1,
  parameter bit          EN_MEXT   = 1'b1
) (
  input logic        clk,
  input logic        rst_n,
  pipe_ctrl_if.slave bus
);

  localparam logic [3:0] LW_CYCLES = 4'(LOAD_WAIT);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SLL   = 5'd2;
  localparam logic [4:0] ALU_SLT   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_OR    = 5'd8;
  localparam logic [4:0] ALU_AND   = 5'd9;
  localparam logic [4:0] ALU_PASSB = 5'd10;
  localparam logic [4:0] ALU_MUL   = 5'd11;
  localparam logic [4:0] ALU_INV   = 5'd31;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] BR_NONE   = 2'b00;
  localparam logic [1:0] BR_BRANCH = 2'b01;
  localparam logic [1:0] BR_JUMP   = 2'b10;

  typedef enum logic [1:0] {ST_RUN, ST_LWAIT, ST_MDWAIT} state_e;

  typedef struct packed {
    logic [4:0] alu_op;
    logic       reg_write;
    logic       read_en;
    logic       write_en;
    logic       sel_a;
    logic       sel_b;
    logic [1:0] wb_sel;
    logic [1:0] br_type;
    logic       valid;
  } ctrl_t;

  // A bubble is the all-zero control word, the same as the reset value.
  localparam ctrl_t BUBBLE = '0;

  // Base arithmetic mapping shared by R-type and I-type for funct3.
  function automatic logic [4:0] base_alu(input logic [2:0] f3);
    logic [4:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       md_first_q, md_first_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       illegal_q, illegal_d;

  ctrl_t dec;
  logic  dec_legal;
  logic  dec_load;
  logic  dec_md;

  logic  pc_en;
  logic  wb_en;
  logic  md_start;
  logic  flush;
  logic  capture;

  // ---------------------------------------------------------------- decode
  // NOTE: every always_comb output gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    dec           = BUBBLE;
    dec.valid     = 1'b1;
    dec.wb_sel    = WB_ALU;
    dec.alu_op    = ALU_ADD;
    dec_legal     = 1'b1;
    dec_load      = 1'b0;
    dec_md        = 1'b0;

    case (bus.opcode)
      OP_R: begin
        dec.sel_a     = 1'b1;
        dec.sel_b     = 1'b1;
        dec.reg_write = 1'b1;
        case (bus.funct7)
          7'b0000000: dec.alu_op = base_alu(bus.funct3);
          7'b0100000: begin
            if (bus.funct3 == 3'b000)      dec.alu_op = ALU_SUB;
            else if (bus.funct3 == 3'b101) dec.alu_op = ALU_SRA;
            else                           dec_legal  = 1'b0;
          end
          7'b0000001: begin
            // MUL..REMU occupy codes 11..18 in funct3 order.
            if (EN_MEXT) begin
              dec.alu_op = ALU_MUL + {2'b00, bus.funct3};
              dec_md     = 1'b1;
            end else begin
              dec_legal  = 1'b0;
            end
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OP_I: begin
        dec.sel_a     = 1'b1;
        dec.reg_write = 1'b1;
        case (bus.funct3)
          3'b001: begin
            if (bus.funct7 == 7'b0000000) dec.alu_op = ALU_SLL;
            else                          dec_legal  = 1'b0;
          end
          3'b101: begin
            // funct7[5] picks SRAI over SRLI; other funct7 bits must be 0.
            if ({bus.funct7[6], bus.funct7[4:0]} == 6'b0)
              dec.alu_op = bus.funct7[5] ? ALU_SRA : ALU_SRL;
            else
              dec_legal  = 1'b0;
          end
          default: dec.alu_op = base_alu(bus.funct3);
        endcase
      end
      OP_LOAD: begin
        dec.sel_a     = 1'b1;
        dec.read_en   = 1'b1;
        dec.reg_write = 1'b1;
        dec.wb_sel    = WB_MEM;
        dec_load      = 1'b1;
        // LB, LH, LW, LBU, LHU only.
        if (bus.funct3 == 3'b011 || bus.funct3[2:1] == 2'b11) dec_legal = 1'b0;
      end
      OP_STORE: begin
        dec.sel_a    = 1'b1;
        dec.write_en = 1'b1;
        if (bus.funct3 != 3'b010) dec_legal = 1'b0;
      end
      OP_BRANCH: begin
        dec.br_type = BR_BRANCH;
        if (bus.funct3[2:1] == 2'b01) dec_legal = 1'b0;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_PASSB;
      end
      OP_JAL: begin
        dec.reg_write = 1'b1;
        dec.wb_sel    = WB_PC4;
        dec.br_type   = BR_JUMP;
      end
      OP_JALR: begin
        dec.sel_a     = 1'b1;
        dec.reg_write = 1'b1;
        dec.wb_sel    = WB_PC4;
        dec.br_type   = BR_JUMP;
        if (bus.funct3 != 3'b000) dec_legal = 1'b0;
      end
      default: dec_legal = 1'b0;
    endcase

    if (!dec_legal) begin
      dec.alu_op = ALU_INV;
      dec_load   = 1'b0;
      dec_md     = 1'b0;
    end
  end

  // ------------------------------------------------- pipeline control outputs
  always_comb begin
    pc_en    = 1'b1;
    wb_en    = 1'b0;
    md_start = 1'b0;
    case (state_q)
      ST_RUN: wb_en = ctrl_q.valid & ctrl_q.reg_write;
      ST_LWAIT: begin
        pc_en = (cnt_q == 4'd0);
        wb_en = pc_en & ctrl_q.valid & ctrl_q.reg_write;
      end
      ST_MDWAIT: begin
        // md_done is accepted even in the start cycle.
        pc_en    = bus.md_done;
        wb_en    = bus.md_done & ctrl_q.valid & ctrl_q.reg_write;
        md_start = md_first_q;
      end
      default: pc_en = 1'b1;
    endcase
  end

  // Control flow resolves in stage 2, which never stalls on it, so a flush
  // and a stall never overlap.
  assign flush = ctrl_q.valid &
                 ((ctrl_q.br_type == BR_JUMP) |
                  ((ctrl_q.br_type == BR_BRANCH) & bus.br_taken));

  assign capture = bus.instr_valid & ~flush & dec_legal;

  // ------------------------------------------------------------ next state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    md_first_d = 1'b0;
    ctrl_d     = ctrl_q;
    illegal_d  = 1'b0;

    if (pc_en) begin
      ctrl_d    = capture ? dec : BUBBLE;
      illegal_d = bus.instr_valid & ~flush & ~dec_legal;
      state_d   = ST_RUN;
      cnt_d     = 4'd0;
      if (capture && dec_load && LW_CYCLES != 4'd0) begin
        state_d = ST_LWAIT;
        cnt_d   = LW_CYCLES;
      end else if (capture && dec_md) begin
        state_d    = ST_MDWAIT;
        md_first_d = 1'b1;
      end
    end else if (state_q == ST_LWAIT) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      cnt_q      <= 4'd0;
      md_first_q <= 1'b0;
      ctrl_q     <= BUBBLE;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      md_first_q <= md_first_d;
      ctrl_q     <= ctrl_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.alu_op     = ctrl_q.alu_op;
  assign bus.reg_write  = ctrl_q.reg_write;
  assign bus.read_en    = ctrl_q.read_en;
  assign bus.write_en   = ctrl_q.write_en;
  assign bus.sel_A      = ctrl_q.sel_a;
  assign bus.sel_B      = ctrl_q.sel_b;
  assign bus.wb_sel     = ctrl_q.wb_sel;
  assign bus.br_type    = ctrl_q.br_type;
  assign bus.ctrl_valid = ctrl_q.valid;
  assign bus.wb_en      = wb_en;
  assign bus.PCen       = pc_en;
  assign bus.flush      = flush;
  assign bus.md_start   = EN_MEXT & md_start;
  assign bus.illegal    = illegal_q;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Registered, parametrised successor to the single-cycle decode controller for the 3-stage RV32I pipeline. It sits between fetch/decode and the execute/memory/writeback stage. It decodes the opcode fields into control signals and holds them in a stage-2 control register. It also generates the pipeline control: a PC enable for stalls, a flush for taken control flow, multi-cycle load wait states, an optional M-extension start/done handshake, and illegal-instruction reporting.

## Interface
- LOAD_WAIT, default 1: extra cycles a load spends in stage 2 before its writeback (0–15; 0 means a single-cycle load).
- EN_MEXT, default 1: 1 decodes MUL/DIV/REM (R-type, funct7=0000001); 0 treats them as illegal.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- instr_valid  in  1  the opcode/funct fields carry a valid fetched instruction.
- opcode  in  7;  funct3  in  3;  funct7  in  7  decode fields.
- br_taken  in  1  branch comparator result for the stage-2 instruction.
- md_done  in  1  multi-cycle MUL/DIV unit result ready.
- alu_op  out  5  stage-2 ALU operation.
- reg_write, read_en, write_en, sel_A, sel_B  out  1 each  stage-2 controls.
- wb_sel  out  2  writeback source: 00 memory, 01 ALU, 10 PC+4.
- br_type  out  2  control-flow class: 00 none, 01 branch, 10 jump.
- ctrl_valid  out  1  stage 2 holds a real instruction, not a bubble.
- wb_en  out  1  register-file write strobe, already qualified.
- PCen  out  1  fetch/PC advance enable.
- flush  out  1  discard the currently fetched instruction.
- md_start  out  1  one-cycle start pulse to the MUL/DIV unit.
- illegal  out  1  one-cycle pulse on an illegal opcode or funct combination.

## Operation
- alu_op codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
  - 11 MUL, 12 MULH, 13 MULHSU, 14 MULHU, 15 DIV, 16 DIVU, 17 REM, 18 REMU.
  - 31 invalid.
- Decode per opcode:
  - R-type and I-type: standard mapping; SRLI/SRAI are selected by funct7[5].
  - Load: sel_A=1, sel_B=0, ADD, read_en=1, wb_sel=00.
  - Store (funct3=010 only): sel_A=1, sel_B=0, ADD, write_en=1, reg_write=0.
  - Branch: sel_A=0, sel_B=0, ADD, br_type=01.
  - AUIPC: sel_A=0, sel_B=0, ADD.
  - LUI: sel_B=0, PASSB.
  - JAL: sel_A=0. JALR: sel_A=1. Both use ADD, br_type=10, wb_sel=10, reg_write=1.
- Every control signal is defined for every opcode. There are no latches.
- An unknown opcode or undefined funct combination captures a bubble and pulses illegal the next cycle.
- Capture: on each edge with PCen=1, the stage-2 register loads the decoded instruction if instr_valid=1. It loads a bubble if instr_valid=0 or flush=1.
  - A bubble means ctrl_valid=0, reg_write=read_en=write_en=0, br_type=00, alu_op=0.
- FSM states: RUN, LWAIT, MDWAIT.
  - Capturing a load with LOAD_WAIT>0 enters LWAIT with cnt=LOAD_WAIT.
  - Capturing a MUL/DIV enters MDWAIT. Everything else stays in RUN.
- LWAIT: PCen=0 and cnt decrements each cycle. When cnt=0, PCen=1, wb_en=1, and the FSM returns to RUN (or enters the next state on a new capture).
- MDWAIT: md_start=1 only in the first cycle in MDWAIT. PCen=0 until md_done=1. In the md_done cycle, PCen=1 and wb_en=1. md_done is honoured in the start cycle too.
- RUN: wb_en = ctrl_valid & reg_write. PCen=1.
- flush = ctrl_valid & ((br_type=10) | (br_type=01 & br_taken)). Control-flow instructions never stall, so flush and a stall never coincide.
- EN_MEXT=0: no MDWAIT entry. md_start is tied to 0.

## Timing
- Reset values: all stage-2 outputs 0, alu_op=0, ctrl_valid=0, wb_en=0, flush=0, md_start=0, illegal=0, PCen=1, FSM in RUN, cnt=0.
- Reset asserted mid-stall abandons the load or MUL/DIV, with no wb_en and no further md_start.
- Decode-to-stage-2 latency is one cycle. PCen, wb_en and flush are combinational from stage-2 state plus br_taken/md_done.
- A load occupies stage 2 for LOAD_WAIT+1 cycles and asserts wb_en in the last of them only.
- A MUL/DIV occupies stage 2 from capture through the md_done cycle.
- A flush cycle is followed by exactly one bubble in stage 2.
- Back-to-back stalling instructions are allowed: a load captured on a load's release edge re-enters LWAIT with no gap.

## Test plan
- Reset, then ADD x1,x2,x3 with instr_valid=1 → next cycle alu_op=0, reg_write=1, wb_sel=01, ctrl_valid=1, wb_en=1, PCen=1.
- LOAD_WAIT=2, LW → PCen=0 for 2 cycles, wb_en=1 only in the 3rd cycle, read_en=1 throughout.
- EN_MEXT=1, MUL, md_done at start+4 → md_start for 1 cycle, PCen=0 for 4 cycles, wb_en=1 and alu_op=11 on the done cycle.
- BEQ with br_taken=1 → flush=1 for one cycle, the next stage-2 ctrl_valid=0. With br_taken=0 → no flush.
- opcode 0000000, or EN_MEXT=0 with DIV → illegal pulses one cycle, the stage-2 register holds a bubble, wb_en=0.
- rst_n low during MDWAIT → all outputs at reset values immediately, PCen=1, and no md_start after release.
